// File: rtl/node_pkg.sv
// node_pkg: constants shared by node and its parameter loader, plus the
// loader state encoding.
package node_pkg;

  // Default node geometry, shared with node.
  localparam int unsigned N_INPUTS    = 8;
  localparam int unsigned WEIGHT_BITS = 5;
  localparam int unsigned INPUT_BITS  = 5;
  localparam int unsigned SUM_BITS    = 13;
  localparam int unsigned OUTPUT_BITS = 8;
  localparam int unsigned IDX_BITS    = 4;

  // Loader state encoding.
  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/node_param_loader_if.sv
// node_param_loader_if: valid/ready word stream feeding the parameter loader.
//   s_valid  producer has a word
//   s_data   weight or bias word
//   s_last   final (bias) word of a frame
//   s_ready  loader accepts a word this cycle
// master = word producer, slave = loader.
interface node_param_loader_if
  import node_pkg::*;
#(
  parameter int unsigned WEIGHT_BITS = node_pkg::WEIGHT_BITS
);
  logic                   s_valid;
  logic [WEIGHT_BITS-1:0] s_data;
  logic                   s_last;
  logic                   s_ready;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/param_bank.sv
// param_bank: N_WORDS x W register bank with single-word indexed write and a
// whole-bank parallel load (load wins if both are requested).
//   clk, rst_n    clock, async active-low reset (bank clears to 0)
//   i_wr_en       write i_wr_data into word i_wr_idx
//   i_load_en     replace the whole bank with i_load_data
//   o_data        packed bank, word k at [k*W +: W]
module param_bank
  import node_pkg::*;
#(
  parameter int unsigned N_WORDS = N_INPUTS + 1,
  parameter int unsigned W       = WEIGHT_BITS,
  parameter int unsigned IB      = IDX_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [IB-1:0]        i_wr_idx,
  input  logic [W-1:0]         i_wr_data,
  input  logic                 i_load_en,
  input  logic [N_WORDS*W-1:0] i_load_data,
  output logic [N_WORDS*W-1:0] o_data
);

  logic [N_WORDS*W-1:0] r_data;

  // Bank storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load_en) begin
      r_data <= i_load_data;
    end else if (i_wr_en) begin
      for (int unsigned k = 0; k < N_WORDS; k++) begin
        if (i_wr_idx == IB'(k)) begin
          r_data[k*W +: W] <= i_wr_data;
        end
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/node_param_loader.sv
// node_param_loader: assembles a serial weight/bias word stream into the
// packed parameter vectors consumed by node. Frames fill a shadow bank and are
// committed atomically into the active bank when hold is low.
//   clk, rst_n    clock, async active-low reset
//   s_if          word stream (slave side)
//   hold          inference controller freezes the active bank while 1
//   weights       active weights, word k at [k*WEIGHT_BITS +: WEIGHT_BITS]
//   bias          active bias
//   params_valid  active bank holds a committed frame (sticky until reset)
//   commit        one-cycle pulse, aligned with new active values appearing
//   frame_err     one-cycle pulse on a short or long frame
//   err_count     saturating frame error count (only with
//                 NODE_PARAM_LOADER_ERR_CNT_EN defined)
module node_param_loader
  import node_pkg::*;
#(
  parameter int unsigned N_INPUTS    = node_pkg::N_INPUTS,
  parameter int unsigned WEIGHT_BITS = node_pkg::WEIGHT_BITS,
  parameter int unsigned IDX_BITS    = node_pkg::IDX_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  node_param_loader_if.slave              s_if,
  input  logic                            hold,
  output logic [N_INPUTS*WEIGHT_BITS-1:0] weights,
  output logic [WEIGHT_BITS-1:0]          bias,
  output logic                            params_valid,
  output logic                            commit,
  output logic                            frame_err
`ifdef NODE_PARAM_LOADER_ERR_CNT_EN
  ,
  output logic [7:0]                      err_count
`endif
);

  localparam int unsigned  LP_BANK_W   = (N_INPUTS + 1) * WEIGHT_BITS;
  localparam logic [IDX_BITS-1:0] LP_BIAS_IDX = IDX_BITS'(N_INPUTS);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [IDX_BITS-1:0]  r_idx;
  logic [IDX_BITS-1:0]  w_idx_nxt;
  logic                 r_ready;
  logic                 r_commit;
  logic                 r_frame_err;
  logic                 r_params_valid;
  logic                 w_xfer;
  logic                 w_wr_en;
  logic                 w_err;
  logic                 w_load;
  logic [LP_BANK_W-1:0] w_shadow;
  logic [LP_BANK_W-1:0] w_active;

  assign w_xfer      = s_if.s_valid && r_ready;
  assign s_if.s_ready = r_ready;

  // State and word index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state, shadow write, error and commit decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_en     = 1'b0;
    w_err       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_xfer) begin
          if (r_idx < LP_BIAS_IDX) begin
            if (s_if.s_last) begin
              // Short frame: restart; the next frame rewrites every slot.
              w_err     = 1'b1;
              w_idx_nxt = '0;
            end else begin
              w_wr_en   = 1'b1;
              w_idx_nxt = r_idx + IDX_BITS'(1);
            end
          end else if (s_if.s_last) begin
            // Bias word lands in the last bank slot.
            w_wr_en     = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = ST_PENDING;
          end else begin
            // Long frame: discard the remainder up to s_last.
            w_err       = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_PENDING: begin
        if (!hold) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (w_xfer && s_if.s_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // Registered status outputs; s_ready tracks the state being entered so it
  // stays low through reset and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready        <= 1'b0;
      r_commit       <= 1'b0;
      r_frame_err    <= 1'b0;
      r_params_valid <= 1'b0;
    end else begin
      r_ready        <= (w_state_nxt != ST_PENDING);
      r_commit       <= w_load;
      r_frame_err    <= w_err;
      r_params_valid <= r_params_valid | w_load;
    end
  end

  param_bank #(
    .N_WORDS (N_INPUTS + 1),
    .W       (WEIGHT_BITS),
    .IB      (IDX_BITS)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_idx),
    .i_wr_data   (s_if.s_data),
    .i_load_en   (1'b0),
    .i_load_data ('0),
    .o_data      (w_shadow)
  );

  param_bank #(
    .N_WORDS (N_INPUTS + 1),
    .W       (WEIGHT_BITS),
    .IB      (IDX_BITS)
  ) u_active (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (1'b0),
    .i_wr_idx    ('0),
    .i_wr_data   ('0),
    .i_load_en   (w_load),
    .i_load_data (w_shadow),
    .o_data      (w_active)
  );

`ifdef NODE_PARAM_LOADER_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating frame error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

  assign weights      = w_active[N_INPUTS*WEIGHT_BITS-1:0];
  assign bias         = w_active[LP_BANK_W-1 -: WEIGHT_BITS];
  assign params_valid = r_params_valid;
  assign commit       = r_commit;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_node_param_loader.sv
// tb_node_param_loader: directed scenarios plus randomized traffic, checked
// every cycle against a frame-level reference model.
module tb_node_param_loader;

  localparam int N = 8;
  localparam int W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic hold  = 1'b0;
  always #5 clk = ~clk;

  node_param_loader_if #(.WEIGHT_BITS(W)) s_if ();

  logic [N*W-1:0] weights;
  logic [W-1:0]   bias;
  logic           params_valid;
  logic           commit;
  logic           frame_err;
`ifdef NODE_PARAM_LOADER_ERR_CNT_EN
  logic [7:0]     err_count;
`endif

  node_param_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (s_if),
    .hold         (hold),
    .weights      (weights),
    .bias         (bias),
    .params_valid (params_valid),
    .commit       (commit),
    .frame_err    (frame_err)
`ifdef NODE_PARAM_LOADER_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit             m_ready, m_pv, m_commit, m_err, m_pending, m_drain, m_xfer;
  logic [W-1:0]   m_cur[$];
  logic [W-1:0]   m_shadow[$];
  logic [N*W-1:0] m_w;
  logic [W-1:0]   m_b;
  int             m_errcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_pv = 0; m_commit = 0; m_err = 0;
      m_pending = 0; m_drain = 0; m_w = '0; m_b = '0; m_errcnt = 0;
      m_cur.delete();
    end else begin
      m_xfer   = s_if.s_valid && m_ready;
      m_commit = 0;
      m_err    = 0;
      if (m_pending) begin
        if (!hold) begin
          for (int k = 0; k < N; k++) m_w[k*W +: W] = m_shadow[k];
          m_b = m_shadow[N];
          m_pv = 1; m_commit = 1; m_pending = 0;
        end
      end else if (m_xfer) begin
        if (m_drain) begin
          if (s_if.s_last) m_drain = 0;
        end else begin
          m_cur.push_back(s_if.s_data);
          if (m_cur.size() <= N) begin
            if (s_if.s_last) begin m_err = 1; m_cur.delete(); end
          end else begin
            if (s_if.s_last) begin m_shadow = m_cur; m_pending = 1; end
            else begin m_err = 1; m_drain = 1; end
            m_cur.delete();
          end
        end
      end
      if (m_err && m_errcnt < 255) m_errcnt++;
      m_ready = !m_pending;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("s_ready",      64'(s_if.s_ready),  64'(m_ready));
    chk("weights",      64'(weights),       64'(m_w));
    chk("bias",         64'(bias),          64'(m_b));
    chk("params_valid", 64'(params_valid),  64'(m_pv));
    chk("commit",       64'(commit),        64'(m_commit));
    chk("frame_err",    64'(frame_err),     64'(m_err));
`ifdef NODE_PARAM_LOADER_ERR_CNT_EN
    chk("err_count",    64'(err_count),     64'(m_errcnt));
`endif
  end

  // Pulse bookkeeping for literal timing checks.
  int cyc = 0, commit_seen = 0, err_seen = 0, last_commit = 0, prev_commit = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (commit === 1'b1) begin
      commit_seen++; prev_commit = last_commit; last_commit = cyc;
    end
    if (frame_err === 1'b1) err_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [W-1:0] d, input bit l);
    @(negedge clk); #1;
    s_if.s_valid = v; s_if.s_data = d; s_if.s_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, 0);
  endtask

  // Present a word and return just after the edge that transfers it.
  task automatic send_word(input logic [W-1:0] d, input bit l);
    int n;
    drive(1, d, l);
    n = 0;
    while (s_if.s_ready !== 1'b1 && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 60) begin
      checks++; failures++;
      $display("FAIL send_word_timeout actual=no_ready required=ready (t=%0t)", $time);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] first, input logic [W-1:0] b);
    for (int k = 0; k < N; k++) send_word(W'(first + W'(k)), 0);
    send_word(b, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, c0, rc;
    bit v, l;
    logic [W-1:0] d;
    s_if.s_valid = 0; s_if.s_data = '0; s_if.s_last = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready",   64'(s_if.s_ready),  64'd0);
    chk("rst_pv",      64'(params_valid),  64'd0);
    chk("rst_weights", 64'(weights),       64'd0);
    #1 rst_n = 1;
    @(negedge clk);
    chk("ready_after_release", 64'(s_if.s_ready), 64'd1);

    // Nominal frame: words 1..8, bias 5'h1F.
    send_frame(5'd1, 5'h1F);
    @(negedge clk);
    chk("nom_pending_ready", 64'(s_if.s_ready), 64'd0);
    chk("nom_pending_pv",    64'(params_valid), 64'd0);
    #1 s_if.s_valid = 0;
    @(negedge clk);
    chk("nom_weights", 64'(weights),      64'h41CC520C41);
    chk("nom_bias",    64'(bias),         64'h1F);
    chk("nom_pv",      64'(params_valid), 64'd1);
    chk("nom_commit",  64'(commit),       64'd1);
    @(negedge clk);
    chk("nom_commit_once", 64'(commit), 64'd0);

    // Hold blocks the commit.
    #1 hold = 1;
    send_frame(5'd10, 5'd3);
    repeat (20) begin
      @(negedge clk);
      chk("hold_ready", 64'(s_if.s_ready), 64'd0);
      chk("hold_bias",  64'(bias),         64'h1F);
    end
    #1 hold = 0; s_if.s_valid = 0;
    @(negedge clk);
    chk("hold_commit", 64'(commit), 64'd1);
    chk("hold_bias_new", 64'(bias), 64'd3);
    chk("hold_w0", 64'(weights[W-1:0]), 64'd10);

    // Short frame.
    e0 = err_seen;
    send_word(5'd1, 0); send_word(5'd2, 0); send_word(5'd3, 1);
    idle(2);
    chk("short_err_once", 64'(err_seen), 64'(e0 + 1));
    chk("short_bias_kept", 64'(bias), 64'd3);
    send_frame(5'd20, 5'd9);
    idle(3);
    chk("short_next_bias", 64'(bias), 64'd9);
    chk("short_next_w0", 64'(weights[W-1:0]), 64'd20);

    // Long frame: 10 words, s_last on the 10th.
    e0 = err_seen;
    for (int k = 0; k < 9; k++) send_word(W'(k), 0);
    send_word(5'd30, 1);
    idle(3);
    chk("long_err_once", 64'(err_seen), 64'(e0 + 1));
    chk("long_bias_kept", 64'(bias), 64'd9);
    send_frame(5'd5, 5'd7);
    idle(3);
    chk("long_next_bias", 64'(bias), 64'd7);

    // Back-to-back frames.
    c0 = commit_seen;
    send_frame(5'd0, 5'd1);
    send_frame(5'd8, 5'd2);
    idle(4);
    chk("b2b_commits", 64'(commit_seen), 64'(c0 + 2));
    chk("b2b_spacing", 64'(last_commit - prev_commit), 64'd10);
    chk("b2b_bias", 64'(bias), 64'd2);

    // Reset mid-frame.
    for (int k = 0; k < 4; k++) send_word(W'(k + 1), 0);
    #3 rst_n = 0;
    #1;
    chk("midrst_weights", 64'(weights),      64'd0);
    chk("midrst_bias",    64'(bias),         64'd0);
    chk("midrst_pv",      64'(params_valid), 64'd0);
    chk("midrst_ready",   64'(s_if.s_ready), 64'd0);
    s_if.s_valid = 0;
    @(negedge clk); #1 rst_n = 1;
    send_frame(5'd3, 5'd4);
    idle(3);
    chk("midrst_recover_bias", 64'(bias), 64'd4);
    chk("midrst_recover_pv",   64'(params_valid), 64'd1);

`ifdef NODE_PARAM_LOADER_ERR_CNT_EN
    repeat (300) send_word(5'd1, 1);
    idle(2);
    chk("err_count_sat", 64'(err_count), 64'd255);
`endif

    // Randomized traffic.
    rc = 0;
    repeat (3000) begin
      v = ($urandom_range(3) != 0);
      d = W'($urandom);
      l = (rc == N) ? ($urandom_range(7) != 0) : ($urandom_range(19) == 0);
      drive(v, d, l);
      hold = ($urandom_range(3) == 0);
      if (v && s_if.s_ready === 1'b1) rc = (l || rc >= N) ? 0 : rc + 1;
    end
    hold = 0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
